hynoc_local_ingress_arbiter: RTL and testbench
==============================================

# hynoc_local_ingress_arbiter

Packet-granular round-robin arbiter that shares the single local ingress write port of a HyNoC local interface between several on-tile requesters, such as a DMA, a CPU mailbox and a debug port. Each requester presents flits with a valid/ready/last handshake. The block forwards one whole packet at a time onto `local_ingress_write`/`local_ingress_data` and honours `local_ingress_full`. It sits in the local clock domain, directly in front of the local interface ingress FIFO.

## Interface
- `LOG2_NUM_REQ`, 2: log2 of requester count; must be ≥1. `NUM_REQ = 1 << LOG2_NUM_REQ`.
- `FLIT_WIDTH`, 33: flit width in bits; matches the local interface.
- `CNT_WIDTH`, 16: width of the forwarded-packet counter.

- `local_clk`  in  1  clock; one clock only, all logic on its rising edge.
- `local_rstn`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester flit valid.
- `req_last`  in  NUM_REQ  per-requester flag: flit is the last of its packet.
- `req_data`  in  NUM_REQ*FLIT_WIDTH  per-requester flit; requester i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester flit accepted this cycle.
- `local_ingress_write`  out  1  write strobe to the local ingress FIFO.
- `local_ingress_data`  out  FLIT_WIDTH  flit to the local ingress FIFO.
- `local_ingress_full`  in  1  local ingress FIFO full.
- `grant_id`  out  LOG2_NUM_REQ  currently or last granted requester.
- `busy`  out  1  a packet is in progress (state BUSY).
- `pkt_count`  out  CNT_WIDTH  packets forwarded since reset; wraps.

## Operation
- FSM with two states, IDLE and BUSY. Registers:
  - `state`
  - `grant_id`
  - `rr_ptr`: next search start.
  - `pkt_count`
- **Search:** pick the first i with `req_valid[i]=1`, scanning `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
- **IDLE:**
  - If any `req_valid` is high: register grant = search result, go to BUSY.
  - No flit is transferred in the arbitration cycle.
  - Otherwise stay in IDLE.
- **BUSY:** granted requester g.
  - Beat: `req_valid[g]=1` and `local_ingress_full=0`.
  - On a beat: `req_ready[g]=1`, `local_ingress_write=1`, `local_ingress_data=req_data[g]`.
  - On a beat with `req_last[g]=1`:
    - `pkt_count` increments.
    - `rr_ptr` becomes g+1 mod NUM_REQ.
    - Re-search in the same cycle with start g+1. This excludes g unless g is the only valid requester.
    - Hit: grant the hit next cycle and stay in BUSY, giving zero-bubble packet back-to-back.
    - Miss: go to IDLE.
- **Outputs are combinational from state and inputs.**
  - `local_ingress_write = busy & req_valid[g] & !local_ingress_full`.
  - `req_ready` is only ever high for g.
  - `local_ingress_data` is 0 when not writing.
- **Grant hold:** the grant is held for the whole packet. There is no timeout, and a requester deasserting valid mid-packet simply stalls the port.

## Timing
- Reset values:
  - state IDLE.
  - `grant_id`=0, `rr_ptr`=0.
  - `pkt_count`=0.
  - `busy`=0.
  - `req_ready`=0, `local_ingress_write`=0, `local_ingress_data`=0.
- Latency:
  - First beat of a packet from IDLE: one cycle after `req_valid` is seen.
  - Subsequent beats: same cycle as valid & !full.
- Full: while `local_ingress_full=1` no write and no ready. Grant and state are held, and the beat is accepted the first cycle `local_ingress_full=0`.
- Single-flit packet: valid & last on the first beat; transfer and re-arbitration happen in the same cycle.
- `LOG2_NUM_REQ`=1 with only requester 0 active: back-to-back packets from 0 with no bubble.
- `pkt_count` wraps from all-ones to 0.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet is truncated, and downstream recovery is out of scope.
- Simultaneous requests at reset: requester 0 wins first.

## Structure
- Shared HyNoC defines header holds `FLIT_WIDTH` default and the CNT_WIDTH default.
- Sub-module `hynoc_rr_arbiter`: combinational round-robin picker. Inputs are the request vector and start pointer; outputs are hit and index. It is instantiated once and reused for both IDLE and last-beat searches.
- The top level holds the FSM, registers and datapath mux.

## Test plan
- **Reset:** hold `local_rstn`=0 with all valids high → all outputs 0, `grant_id`=0, `pkt_count`=0.
- **Round-robin order:**
  - Stimulus: NUM_REQ=4, all requesters send 3-flit packets continuously, data = {id, seq}.
  - Required: packet order 0,1,2,3,0…; no interleaving within a packet; `pkt_count`=8 after 8 packets; exactly one idle cycle at start, none after.
- **Backpressure:**
  - Stimulus: assert `local_ingress_full` for 5 cycles mid-packet.
  - Required: write=0 and `req_ready`=0 those cycles, grant unchanged, remaining flits delivered in order afterwards.
- **Single-flit packets:**
  - Stimulus: requesters 1 and 3 each send 1-flit packets every cycle.
  - Required: alternating 1,3,1,3 at one flit per cycle.
- **Stall and wrap:**
  - Stimulus: granted requester drops valid for 10 cycles mid-packet while others request.
  - Required: no grant change; packet completes, then the next requester is served.
  - Force `pkt_count` to 0xFFFF and complete a packet → 0x0000.
- **Reset mid-packet:** async reset after the first flit of a 4-flit packet → state IDLE immediately; after release requester 0 is granted first.

Source files
------------

// File: rtl/hynoc_local_ingress_arbiter_pkg.sv
// hynoc_local_ingress_arbiter_pkg: shared HyNoC defaults and arbiter FSM state type
package hynoc_local_ingress_arbiter_pkg;
  localparam int FLIT_WIDTH_DEF = 33;
  localparam int CNT_WIDTH_DEF = 16;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/hynoc_local_ingress_arbiter_if.sv
// hynoc_local_ingress_arbiter_if: requester flit handshake, local ingress write port and arbiter status
// master: drives req_valid/req_last/req_data and local_ingress_full, observes everything else
// slave: the arbiter, drives req_ready, local_ingress_write/data, grant_id, busy, pkt_count
interface hynoc_local_ingress_arbiter_if
  import hynoc_local_ingress_arbiter_pkg::*;
#(
  parameter int LOG2_NUM_REQ = 2,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
  localparam int NUM_REQ = 1 << LOG2_NUM_REQ;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*FLIT_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic local_ingress_write;
  logic [FLIT_WIDTH-1:0] local_ingress_data;
  logic local_ingress_full;
  logic [LOG2_NUM_REQ-1:0] grant_id;
  logic busy;
  logic [CNT_WIDTH-1:0] pkt_count;
  modport master (
    output req_valid, req_last, req_data, local_ingress_full,
    input req_ready, local_ingress_write, local_ingress_data, grant_id, busy, pkt_count
  );
  modport slave (
    input req_valid, req_last, req_data, local_ingress_full,
    output req_ready, local_ingress_write, local_ingress_data, grant_id, busy, pkt_count
  );
endinterface

// File: rtl/hynoc_local_ingress_arbiter_rr.sv
// hynoc_rr_arbiter: combinational round-robin picker, first set request at or after i_start (mod NUM_REQ)
// i_req: request vector, i_start: search start, o_hit: any request, o_idx: chosen index
module hynoc_rr_arbiter #(
  parameter int LOG2_NUM_REQ = 2
) (
  input  logic [(1<<LOG2_NUM_REQ)-1:0] i_req,
  input  logic [LOG2_NUM_REQ-1:0]      i_start,
  output logic                         o_hit,
  output logic [LOG2_NUM_REQ-1:0]      o_idx
);
  localparam int NUM_REQ = 1 << LOG2_NUM_REQ;
  assign o_hit = |i_req;
  // scan offsets from farthest to nearest so the nearest hit is the final assignment;
  // the index sum wraps naturally in LOG2_NUM_REQ bits
  always_comb begin
    o_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (i_req[i_start + LOG2_NUM_REQ'(i)]) o_idx = i_start + LOG2_NUM_REQ'(i);
  end
endmodule

// File: rtl/hynoc_local_ingress_arbiter.sv
// hynoc_local_ingress_arbiter: packet-granular round-robin share of the local ingress write port
// local_clk/local_rstn: clock and async active-low reset
// bus (slave): requester valid/last/data/ready, ingress write/data/full, grant_id, busy, pkt_count
module hynoc_local_ingress_arbiter
  import hynoc_local_ingress_arbiter_pkg::*;
#(
  parameter int LOG2_NUM_REQ = 2,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic local_clk,
  input logic local_rstn,
  hynoc_local_ingress_arbiter_if.slave bus
);
  localparam int NUM_REQ = 1 << LOG2_NUM_REQ;
  state_t r_state;
  logic [LOG2_NUM_REQ-1:0] r_grant, r_ptr, w_start, w_idx;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic w_hit, w_beat, w_done;
  assign w_beat = r_state == BUSY && bus.req_valid[r_grant] && !bus.local_ingress_full;
  assign w_done = w_beat && bus.req_last[r_grant];
  // the last beat re-arbitrates from g+1 in the same cycle, so g is picked again only if alone
  assign w_start = w_done ? r_grant + LOG2_NUM_REQ'(1) : r_ptr;
  hynoc_rr_arbiter #(.LOG2_NUM_REQ(LOG2_NUM_REQ)) u_rr (
    .i_req(bus.req_valid),
    .i_start(w_start),
    .o_hit(w_hit),
    .o_idx(w_idx)
  );
  always_ff @(posedge local_clk or negedge local_rstn)
    if (!local_rstn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_hit) begin
        r_state <= BUSY;
        r_grant <= w_idx;
      end
    end else if (w_done) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
      r_ptr <= w_start;
      if (w_hit) r_grant <= w_idx;
      else r_state <= IDLE;
    end
  assign bus.req_ready = w_beat ? NUM_REQ'(1) << r_grant : '0;
  assign bus.local_ingress_write = w_beat;
  assign bus.local_ingress_data = w_beat ? bus.req_data[32'(r_grant) * FLIT_WIDTH +: FLIT_WIDTH] : '0;
  assign bus.grant_id = r_grant;
  assign bus.busy = r_state == BUSY;
  assign bus.pkt_count = r_cnt;
endmodule

// File: tb/tb_hynoc_local_ingress_arbiter.sv
// tb_hynoc_local_ingress_arbiter: vector table, directed corner sequences and random run against a reference model
module tb_hynoc_local_ingress_arbiter;
  localparam int L = 2, N = 4, FW = 33, CW = 16;
  logic local_clk = 1'b0;
  logic local_rstn = 1'b0;
  always #5 local_clk = ~local_clk;
  hynoc_local_ingress_arbiter_if #(.LOG2_NUM_REQ(L), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) bus ();
  hynoc_local_ingress_arbiter #(.LOG2_NUM_REQ(L), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .local_clk(local_clk), .local_rstn(local_rstn), .bus(bus.slave));
  hynoc_local_ingress_arbiter_if #(.LOG2_NUM_REQ(1), .FLIT_WIDTH(FW), .CNT_WIDTH(4)) b1 ();
  hynoc_local_ingress_arbiter #(.LOG2_NUM_REQ(1), .FLIT_WIDTH(FW), .CNT_WIDTH(4)) dut1 (
    .local_clk(local_clk), .local_rstn(local_rstn), .bus(b1.slave));

  int n_cmp = 0, n_err = 0;
  logic [N-1:0] v, l;
  logic f;
  logic [FW-1:0] d [N];
  int seq [N], rem [N];
  bit m_busy;
  int m_g, m_ptr, m_cnt;
  int gq [$];
  logic [FW-1:0] dq [$];

  typedef struct {
    logic [N-1:0] v, l;
    logic f, w;
    logic [N-1:0] rdy;
    int g;
    logic b;
    int cnt;
  } vec_t;
  vec_t tv [11];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] tdata(int i);
    return {1'b1, 8'(i), 24'hC0FFEE};
  endfunction

  function automatic int pick(logic [N-1:0] vv, int start);
    for (int k = 0; k < N; k++) if (vv[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit beat;
    beat = m_busy && v[m_g] && !f;
    if (!m_busy) begin
      if (v != 0) begin m_g = pick(v, m_ptr); m_busy = 1; end
    end else if (beat && l[m_g]) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (m_g + 1) % N;
      if (v != 0) m_g = pick(v, m_ptr);
      else m_busy = 0;
    end
  endtask

  task automatic compare_model();
    bit beat;
    beat = m_busy && v[m_g] && !f;
    chk("write", bus.local_ingress_write, beat);
    chk("ready", bus.req_ready, beat ? (1 << m_g) : 0);
    chk("data", bus.local_ingress_data, beat ? d[m_g] : 0);
    chk("grant", bus.grant_id, m_g);
    chk("busy", bus.busy, m_busy);
    chk("count", bus.pkt_count, m_cnt);
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) bus.req_data[i*FW +: FW] = d[i];
    bus.req_valid = v;
    bus.req_last = l;
    bus.local_ingress_full = f;
  endtask

  task automatic model_cycle();
    apply();
    @(negedge local_clk);
    compare_model();
    @(posedge local_clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    local_rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge local_clk);
    #1 local_rstn = 1'b1;
  endtask

  // mode 0: random, 1: all requesters 3-flit packets with a 5-cycle full window, 2: req 1 and 3 single flits
  task automatic run(int mode, int cycles);
    bit beat;
    int g;
    gq.delete();
    dq.delete();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      rem[i] = mode == 1 ? 3 : mode == 2 ? 1 : int'($urandom_range(4, 1));
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = mode == 0 ? ($urandom % 4 != 0) : mode == 1 ? 1'b1 : (i == 1 || i == 3);
        l[i] = rem[i] == 1;
        d[i] = {1'b0, 8'(i), 24'(seq[i])};
      end
      f = mode == 0 ? ($urandom % 5 == 0) : (mode == 1 && c >= 8 && c < 13);
      apply();
      @(negedge local_clk);
      compare_model();
      if (bus.local_ingress_write) begin
        gq.push_back(int'(bus.grant_id));
        dq.push_back(bus.local_ingress_data);
      end
      beat = m_busy && v[m_g] && !f;
      g = m_g;
      @(posedge local_clk);
      model_step();
      #1;
      if (beat) begin
        seq[g]++;
        rem[g]--;
        if (rem[g] == 0) rem[g] = mode == 1 ? 3 : mode == 2 ? 1 : int'($urandom_range(4, 1));
      end
    end
  endtask

  initial begin
    tv[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0};
    tv[1]  = '{4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0};
    tv[2]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0010, 1, 1'b1, 0};
    tv[3]  = '{4'b0110, 4'b0010, 1'b1, 1'b0, 4'b0000, 1, 1'b1, 0};
    tv[4]  = '{4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1, 1'b1, 0};
    tv[5]  = '{4'b0110, 4'b0100, 1'b0, 1'b1, 4'b0100, 2, 1'b1, 1};
    tv[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1, 1'b1, 2};
    tv[7]  = '{4'b1010, 4'b1000, 1'b0, 1'b1, 4'b0010, 1, 1'b1, 2};
    tv[8]  = '{4'b1010, 4'b1010, 1'b0, 1'b1, 4'b0010, 1, 1'b1, 2};
    tv[9]  = '{4'b1010, 4'b1000, 1'b0, 1'b1, 4'b1000, 3, 1'b1, 3};
    tv[10] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 1, 1'b1, 4};
    b1.req_valid = '0;
    b1.req_last = '0;
    b1.req_data = '0;
    b1.local_ingress_full = 1'b0;
    v = '1; l = '0; f = 1'b0;
    for (int i = 0; i < N; i++) d[i] = tdata(i);
    apply();
    model_reset();
    @(negedge local_clk);
    chk("rst_write", bus.local_ingress_write, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_data", bus.local_ingress_data, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.pkt_count, 0);
    @(posedge local_clk);
    #1 local_rstn = 1'b1;

    for (int k = 0; k < 11; k++) begin
      v = tv[k].v; l = tv[k].l; f = tv[k].f;
      apply();
      @(negedge local_clk);
      chk("tv_write", bus.local_ingress_write, tv[k].w);
      chk("tv_ready", bus.req_ready, tv[k].rdy);
      chk("tv_data", bus.local_ingress_data, tv[k].w ? tdata(tv[k].g) : '0);
      chk("tv_grant", bus.grant_id, tv[k].g);
      chk("tv_busy", bus.busy, tv[k].b);
      chk("tv_count", bus.pkt_count, tv[k].cnt);
      @(posedge local_clk);
      #1;
    end

    do_reset();
    run(1, 30);
    chk("rr_writes", gq.size(), 24);
    for (int k = 0; k < gq.size() && k < 24; k++) begin
      chk("rr_order", gq[k], (k / 3) % 4);
      chk("rr_data", dq[k], {1'b0, 8'((k / 3) % 4), 24'((k / 12) * 3 + k % 3)});
    end
    chk("rr_count", bus.pkt_count, 8);

    do_reset();
    run(2, 9);
    chk("sf_writes", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) chk("sf_order", gq[k], (k % 2) ? 3 : 1);

    do_reset();
    run(0, 400);

    do_reset();
    v = '1; l = '1; f = 1'b0;
    for (int i = 0; i < N; i++) d[i] = tdata(i);
    model_cycle();
    model_cycle();
    l = '0;
    model_cycle();
    chk("mid_grant_before", bus.grant_id, 1);
    #2 local_rstn = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_write", bus.local_ingress_write, 0);
    chk("mid_ready", bus.req_ready, 0);
    chk("mid_grant", bus.grant_id, 0);
    model_reset();
    @(posedge local_clk);
    #1 local_rstn = 1'b1;
    model_cycle();
    model_cycle();
    chk("mid_regrant", bus.grant_id, 0);

    do_reset();
    v = '0; l = '0;
    apply();
    b1.req_valid = 2'b01;
    b1.req_last = 2'b01;
    b1.req_data = {33'd0, 33'h1_2345_6789};
    for (int c = 0; c < 18; c++) begin
      @(negedge local_clk);
      chk("w1_write", b1.local_ingress_write, c != 0);
      if (c > 0) begin
        chk("w1_count", b1.pkt_count, (c - 1) % 16);
        chk("w1_data", b1.local_ingress_data, 33'h1_2345_6789);
      end
      @(posedge local_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
